// File: rtl/arrayadd_pkg.sv
// Shared types and default widths for the array-add datapath.
// LAST_INDEX here matches the default IDX_W; modules derive their own from their parameter.
package arrayadd_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int IDX_W_DEF  = 8;
    localparam int ACC_W_DEF  = 40;
    localparam int LAST_INDEX = (1 << IDX_W_DEF) - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } red_state_t;

endpackage

// File: rtl/minmax_tracker.sv
// Unsigned running min/max with a load (first element) and an update enable.
// The next-state values are exported so the parent can capture them in the same edge.
module minmax_tracker #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              update,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] min_q,
    output logic [DATA_W-1:0] max_q,
    output logic [DATA_W-1:0] min_nxt,
    output logic [DATA_W-1:0] max_nxt
);

    always_comb begin
        min_nxt = min_q;
        max_nxt = max_q;
        if (load) begin
            min_nxt = din;
            max_nxt = din;
        end else if (update) begin
            if (din < min_q) min_nxt = din;
            if (din > max_q) max_nxt = din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            min_q <= '0;
            max_q <= '0;
        end else begin
            min_q <= min_nxt;
            max_q <= max_nxt;
        end
    end

endmodule

// File: rtl/sum_reducer.sv
// Reduces one full index sweep of {index, sum} beats into total/min/max/count
// and presents it on a valid/ready result port, stalling the input while pending.
module sum_reducer
    import arrayadd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [IDX_W-1:0]  in_index,
    input  logic [DATA_W-1:0] in_sum,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_total,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max,
    output logic [IDX_W:0]    out_count,
    output logic              out_seq_err,
    output logic              out_overflow
);

    localparam logic [IDX_W-1:0] LAST_IDX  = {IDX_W{1'b1}};
    localparam logic [IDX_W:0]   COUNT_MAX = {1'b1, {IDX_W{1'b0}}};

    red_state_t        state;
    logic [ACC_W-1:0]  total;
    logic [IDX_W:0]    count;
    logic [IDX_W-1:0]  expected;
    logic              seq_err;
    logic              overflow;

    logic              acc;
    logic              mm_load;
    logic              mm_update;
    logic [DATA_W-1:0] min_q, max_q, min_nxt, max_nxt;
    logic [ACC_W:0]    sum_wide;
    logic [IDX_W:0]    count_inc;
    logic              seq_err_nxt;
    logic              overflow_nxt;

    assign acc       = in_valid & in_ready;
    assign mm_load   = acc && (state == IDLE) && (in_index == '0);
    assign mm_update = acc && (state == ACCUM);

    // One extra bit catches the carry out of the accumulator.
    assign sum_wide     = {1'b0, total} + (ACC_W+1)'(in_sum);
    assign count_inc    = (count == COUNT_MAX) ? count : count + (IDX_W+1)'(1);
    assign seq_err_nxt  = seq_err | (in_index != expected);
    assign overflow_nxt = overflow | sum_wide[ACC_W];

    minmax_tracker #(.DATA_W(DATA_W)) u_minmax (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (mm_load),
        .update  (mm_update),
        .din     (in_sum),
        .min_q   (min_q),
        .max_q   (max_q),
        .min_nxt (min_nxt),
        .max_nxt (max_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            total        <= '0;
            count        <= '0;
            expected     <= '0;
            seq_err      <= 1'b0;
            overflow     <= 1'b0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_total    <= '0;
            out_min      <= '0;
            out_max      <= '0;
            out_count    <= '0;
            out_seq_err  <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Beats before index 0 belong to a partial sweep and are dropped.
                    if (acc && in_index == '0) begin
                        total    <= ACC_W'(in_sum);
                        count    <= (IDX_W+1)'(1);
                        expected <= (IDX_W)'(1);
                        seq_err  <= 1'b0;
                        overflow <= 1'b0;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (acc) begin
                        total    <= sum_wide[ACC_W-1:0];
                        count    <= count_inc;
                        expected <= in_index + (IDX_W)'(1);
                        seq_err  <= seq_err_nxt;
                        overflow <= overflow_nxt;
                        if (in_index == LAST_IDX) begin
                            // Capture the result including this last beat.
                            out_total    <= sum_wide[ACC_W-1:0];
                            out_min      <= min_nxt;
                            out_max      <= max_nxt;
                            out_count    <= count_inc;
                            out_seq_err  <= seq_err_nxt;
                            out_overflow <= overflow_nxt;
                            out_valid    <= 1'b1;
                            in_ready     <= 1'b0;
                            state        <= REPORT;
                        end
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_reducer.sv
// Directed bench for sum_reducer: default widths plus an ACC_W=32 copy for overflow.
module tb_sum_reducer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_index;
    logic [31:0] in_sum;
    logic        out_ready;

    logic        in_ready, out_valid, seq_err, ovf;
    logic [39:0] total;
    logic [31:0] mn, mx;
    logic [8:0]  cnt;

    logic        o_in_ready, o_out_valid, o_seq_err, o_ovf;
    logic [31:0] o_total, o_mn, o_mx;
    logic [8:0]  o_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sum_reducer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_index(in_index),
        .in_sum(in_sum), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_total(total), .out_min(mn), .out_max(mx),
        .out_count(cnt), .out_seq_err(seq_err), .out_overflow(ovf)
    );

    sum_reducer #(.DATA_W(32), .IDX_W(8), .ACC_W(32)) dut_ov (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_index(in_index),
        .in_sum(in_sum), .in_ready(o_in_ready), .out_valid(o_out_valid),
        .out_ready(out_ready), .out_total(o_total), .out_min(o_mn), .out_max(o_mx),
        .out_count(o_cnt), .out_seq_err(o_seq_err), .out_overflow(o_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic beat(input int idx, input logic [31:0] s);
        @(negedge clk);
        in_valid = 1'b1;
        in_index = 8'(idx);
        in_sum   = s;
    endtask

    task automatic hole();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called right after the index-255 beat; checks latency-1 valid, waits bounded otherwise.
    task automatic end_sweep(input string tag, input bit hold0);
        @(negedge clk);
        if (hold0) begin
            in_valid = 1'b1;
            in_index = 8'd0;
            in_sum   = 32'd7;
        end else begin
            in_valid = 1'b0;
        end
        chk({tag, "_lat1_valid"}, 64'(out_valid), 64'd1);
        for (int k = 0; k < 8 && !out_valid; k++) @(negedge clk);
        if (!out_valid) chk({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic rpt(input string tag, input logic [39:0] t, input logic [31:0] lo,
                       input logic [31:0] hi, input int c, input bit se, input bit ov);
        chk({tag, "_total"}, 64'(total), 64'(t));
        chk({tag, "_min"}, 64'(mn), 64'(lo));
        chk({tag, "_max"}, 64'(mx), 64'(hi));
        chk({tag, "_count"}, 64'(cnt), 64'(c));
        chk({tag, "_seq_err"}, 64'(seq_err), 64'(se));
        chk({tag, "_overflow"}, 64'(ovf), 64'(ov));
        chk({tag, "_in_ready_low"}, 64'(in_ready), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_index = '0; in_sum = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_total", 64'(total), 64'd0);
        chk("rst_count", 64'(cnt), 64'd0);
        chk("rst_minmax", 64'({mn, mx}), 64'd0);
        chk("rst_flags", 64'({seq_err, ovf}), 64'd0);
        rst_n = 1'b1;

        // Clean sweep: sum = index+1
        for (int i = 0; i < 256; i++) beat(i, 32'(i + 1));
        end_sweep("clean", 1'b0);
        rpt("clean", 40'd32896, 32'd1, 32'd256, 256, 1'b0, 1'b0);
        chk("clean_ov_flag", 64'(o_ovf), 64'd0);
        @(negedge clk);
        chk("clean_valid_1cyc", 64'(out_valid), 64'd0);
        chk("clean_in_ready_back", 64'(in_ready), 64'd1);

        // Back-pressure: hold result 10 cycles with index 0 of next sweep waiting
        out_ready = 1'b0;
        for (int i = 0; i < 256; i++) beat(i, 32'd1000);
        end_sweep("bp", 1'b1);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            chk("bp_valid_hold", 64'(out_valid), 64'd1);
            chk("bp_total_stable", 64'(total), 64'd256000);
        end
        rpt("bp", 40'd256000, 32'd1000, 32'd1000, 256, 1'b0, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_drop", 64'(out_valid), 64'd0);
        chk("bp_in_ready_back", 64'(in_ready), 64'd1);
        for (int i = 1; i < 256; i++) beat(i, 32'd7);
        end_sweep("bp_next", 1'b0);
        rpt("bp_next", 40'd1792, 32'd7, 32'd7, 256, 1'b0, 1'b0);

        // Pre-sync drop then sweep with holes: sum = 3*index
        for (int i = 200; i < 256; i++) beat(i, 32'd99);
        hole();
        chk("presync_no_report", 64'(out_valid), 64'd0);
        for (int i = 0; i < 256; i++) begin
            if (i % 16 == 5) hole();
            beat(i, 32'(3 * i));
        end
        end_sweep("holes", 1'b0);
        rpt("holes", 40'd97920, 32'd0, 32'd765, 256, 1'b0, 1'b0);

        // Sequence error: skip index 17
        for (int i = 0; i < 256; i++) if (i != 17) beat(i, 32'd10);
        end_sweep("seq", 1'b0);
        rpt("seq", 40'd2550, 32'd10, 32'd10, 255, 1'b1, 1'b0);

        // Overflow: ACC_W=32 copy overflows, 40-bit copy does not
        for (int i = 0; i < 256; i++) beat(i, 32'hFFFF_FFFF);
        end_sweep("ovf", 1'b0);
        rpt("ovf_wide", 40'hFF_FFFF_FF00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 256, 1'b0, 1'b0);
        chk("ovf_narrow_valid", 64'(o_out_valid), 64'd1);
        chk("ovf_narrow_flag", 64'(o_ovf), 64'd1);
        chk("ovf_narrow_min", 64'(o_mn), 64'hFFFF_FFFF);
        chk("ovf_narrow_max", 64'(o_mx), 64'hFFFF_FFFF);
        chk("ovf_narrow_total", 64'(o_total), 64'hFFFF_FF00);
        chk("ovf_narrow_count", 64'(o_cnt), 64'd256);

        // Reset mid-sweep at index 100, then a clean sweep of 5s
        for (int i = 0; i < 100; i++) beat(i, 32'd5);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b1; in_index = 8'd100; in_sum = 32'd5;
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_count_clr", 64'(cnt), 64'd0);
        for (int i = 101; i < 256; i++) beat(i, 32'd5);
        hole();
        chk("midrst_no_report", 64'(out_valid), 64'd0);
        for (int i = 0; i < 256; i++) beat(i, 32'd5);
        end_sweep("postrst", 1'b0);
        rpt("postrst", 40'd1280, 32'd5, 32'd5, 256, 1'b0, 1'b0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sum_reducer.md
Name: sum_reducer

Overview:
- Downstream stage of the array-add datapath.
- Consumes the per-index `{index, sum}` stream produced by the array adder.
- Reduces one full sweep (index 0..2^IDX_W-1) into a total, min, max and beat count, plus sequence and overflow flags.
- Presents the result over a valid/ready handshake and back-pressures the adder's `run` via `in_ready` while the result is pending.

Parameters:
- DATA_W, 32: width of incoming sum word.
- IDX_W, 8: width of incoming index; one sweep is 2^IDX_W beats.
- ACC_W, 40: accumulator width; must be >= DATA_W+IDX_W to be overflow-free.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  beat present; the upstream `run` is driven as `start & in_ready`.
- in_index  in  IDX_W  index of current beat.
- in_sum  in  DATA_W  sum word of current beat.
- in_ready  out  1  beat accepted when `in_valid & in_ready`.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when `out_valid & out_ready`.
- out_total  out  ACC_W  sum of all in_sum in the sweep.
- out_min  out  DATA_W  minimum in_sum of the sweep.
- out_max  out  DATA_W  maximum in_sum of the sweep.
- out_count  out  IDX_W+1  beats accepted in the sweep.
- out_seq_err  out  1  sticky: some beat index differed from expected.
- out_overflow  out  1  sticky: carry out of ACC_W occurred.

Behaviour:
- Reset (`rst_n` low at a clk edge) returns the block to IDLE and clears every output to 0, except `in_ready`, which is 1. Reset mid-sweep or mid-REPORT discards all partial state; no result is emitted.
- FSM states: IDLE, ACCUM, REPORT. Beat accept: `acc = in_valid & in_ready`.
- IDLE, `in_ready = 1`:
  - Accepted beat with `in_index != 0`: dropped, no state change.
  - Accepted beat with `in_index == 0`: the beat is loaded as the first element: `total = in_sum` (zero-extended), `min = max = in_sum`, `count = 1`, `expected = 1`, flags cleared. Next state ACCUM.
- ACCUM, `in_ready = 1`, on each accepted beat:
  - `total += in_sum`, computed at ACC_W+1 bits; the carry sets overflow (sticky).
  - min/max update, using unsigned compare.
  - `count += 1`.
  - `in_index != expected` sets seq_err (sticky); `expected = in_index + 1`, re-synchronising to the received index.
  - Accepted beat with `in_index == 2^IDX_W-1` (all ones): include it, then go to REPORT.
  - Cycles with `in_valid = 0` are holes: no state change.
- REPORT:
  - `in_ready = 0`, so no beat is accepted.
  - `out_*` are registered and stable; `out_valid = 1` from the cycle after the last beat is accepted (latency 1).
  - `out_valid & out_ready`: next state IDLE, `out_valid` drops the next cycle, `in_ready = 1` again. The outputs hold their last values until the next report; the bench checks them only while `out_valid`.
  - `out_ready` held high: one-cycle REPORT, then one IDLE cycle. Index 0 of the next sweep is accepted in IDLE; an index-0 beat presented during REPORT is stalled, not lost.
- `out_count` equals 2^IDX_W for a clean sweep. The counter saturates at 2^IDX_W (all ones in IDX_W+1 bits is unreachable).
- `in_index` wraps naturally: `expected` after index 2^IDX_W-1 is unused.
- Arithmetic is unsigned throughout. With the defaults the overflow flag is unreachable; it is exercised with ACC_W = DATA_W.

Decomposition:
- Shared package `arrayadd_pkg`:
  - FSM state enum (IDLE/ACCUM/REPORT);
  - constants DATA_W, IDX_W, ACC_W defaults;
  - LAST_INDEX = 2^IDX_W-1.
- One natural sub-module: `minmax_tracker` (DATA_W), holding min/max registers with load/update enables.
- All else inline.

Test Plan:
- Clean sweep:
  - Stimulus: `in_sum = index+1` for indices 0..255, `out_ready = 1`.
  - Response: `out_total = 32896`, `out_min = 1`, `out_max = 256`, `out_count = 256`, flags 0, `out_valid` for exactly 1 cycle, 1 cycle after the index-255 beat.
- Back-pressure:
  - Stimulus: `out_ready = 0` for 10 cycles after REPORT entry, with `in_valid` held at index 0.
  - Response: `in_ready = 0` for those 10 cycles, outputs stable, index-0 beat accepted after the handshake.
- Pre-sync drop and holes:
  - Stimulus: start the stream at index 200, and insert `in_valid = 0` gaps during ACCUM.
  - Response: beats 200..255 are ignored; the first report covers only the following 0..255 sweep, unaffected by the gaps.
- Sequence error:
  - Stimulus: skip index 17 (16 is followed by 18).
  - Response: `out_seq_err = 1`, `out_count = 255`, no stall.
- Overflow:
  - Stimulus: ACC_W = 32, all `in_sum = 0xFFFFFFFF`.
  - Response: `out_overflow = 1`, `out_max = out_min = 0xFFFFFFFF`.
- Reset mid-operation:
  - Stimulus: `rst_n = 0` for 1 cycle at index 100, then a full sweep of `in_sum = 5`.
  - Response: no report from the aborted sweep; the next report gives `out_total = 1280`, `out_count = 256`.
